cache_lookup_ctrl: RTL and testbench
====================================

// Module: cache_lookup_ctrl
// PURPOSE
//  Lookup/refill controller that sits directly upstream of the 256x1-bit valid-bit table (cache_table).
//  Owns the per-line tag array and drives the table's RFWr/Addr/WD, consuming its registered RD.
//  Turns CPU lookup requests into hit/miss responses and runs a ready/valid line-refill handshake to memory.
//  Also performs a 256-cycle flush that clears every valid bit.
// PARAMETERS
//  ADDR_W    32  byte-address width of req_addr / mem_req_addr
//  OFFSET_W  2   line-offset bits; zeroed in mem_req_addr
//  INDEX_W   8   line-index bits; fixed at 8 to match the 256-entry table
//  TAG_W     (localparam) ADDR_W-INDEX_W-OFFSET_W
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       synchronous, active-high reset
//  req_valid      in   1       CPU lookup request
//  req_ready      out  1       controller can accept a request (IDLE, no flush pending)
//  req_addr       in   ADDR_W  lookup byte address
//  resp_valid     out  1       one-cycle response pulse
//  resp_hit       out  1       1 = hit, 0 = miss serviced by refill; valid with resp_valid
//  flush_req      in   1       one-cycle pulse; requests invalidation of all lines
//  flush_done     out  1       one-cycle pulse after the last invalidate write
//  mem_req_valid  out  1       refill request to memory
//  mem_req_ready  in   1       memory accepts refill request
//  mem_req_addr   out  ADDR_W  line-aligned refill address (offset bits = 0)
//  mem_resp_valid in   1       refill complete
//  tbl_we         out  1       to table RFWr
//  tbl_addr       out  8       to table Addr
//  tbl_wd         out  1       to table WD
//  tbl_rd         in   1       from table RD (registered; valid 1 cycle after a non-write address)
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 except req_ready=1 after reset; flush_pending=0; flush ctr=0.
//    The table shares rst, so tags need no reset.
//  - States: IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, FLUSH.
//  - IDLE: tbl_we=0, tbl_addr=req_addr index.
//    Priority: flush_pending -> FLUSH (req not accepted); else req_valid&&req_ready latches addr -> LOOKUP.
//  - LOOKUP: tbl_rd is valid; hit = tbl_rd && tag[idx]==addr tag.
//    Hit -> IDLE, resp_valid=1/resp_hit=1 registered next cycle (hit latency: accept T -> resp T+2).
//    Miss -> MISS_REQ.
//  - MISS_REQ: mem_req_valid=1 and mem_req_addr held stable until mem_req_ready; on handshake -> MISS_WAIT.
//  - MISS_WAIT: wait for mem_resp_valid, then FILL. mem_resp_valid in any other state is ignored.
//  - FILL (1 cycle): tbl_we=1, tbl_addr=idx, tbl_wd=1, tag[idx] written; -> IDLE, resp_valid=1/resp_hit=0 next cycle.
//  - FLUSH: counter 0..255; each cycle tbl_we=1, tbl_addr=ctr, tbl_wd=0.
//    After writing 255: counter wraps to 0, flush_done=1 next cycle, -> IDLE.
//  - flush_req in any state sets flush_pending; it is cleared on FLUSH entry.
//    A pulse during FLUSH is absorbed by the running flush; an in-flight miss completes first.
//  - tbl_wd=0 whenever tbl_we=0. req_ready=0 in every state except IDLE, and in IDLE while flush_pending.
//  - rst asserted mid-miss or mid-flush: immediate return to IDLE; mem_req_valid drops; no resp/flush_done.
// CONFIGURATION
//  CACHE_STATS_EN defined:
//   - adds outputs hit_cnt[31:0] and miss_cnt[31:0].
//   - hit_cnt increments with each hit resp; miss_cnt with each miss resp.
//   - counters wrap at 2^32, are cleared by rst only, and are unaffected by flush.
//  CACHE_STATS_EN undefined: counter ports and logic are absent; all other behaviour is identical.
// TESTING
//  1. After rst, req 0x0000_0104: miss -> mem_req_addr=0x0000_0104, resp_hit=0.
//     Repeat the same address -> resp_hit=1 at T+2.
//  2. Fill 0x0000_0104, then req 0x0001_0104 (same idx 0x41, other tag) -> miss and refill.
//     Re-request 0x0000_0104 -> miss.
//  3. Hold mem_req_ready=0 for 5 cycles: mem_req_valid stays 1 with a stable address; no resp; req_ready=0.
//  4. Fill idx 0 and idx 255, pulse flush_req: 256 writes with wd=0, then flush_done.
//     Both addresses now miss; a req_valid held during the flush is not accepted until IDLE.
//  5. flush_req during MISS_WAIT -> miss resp first, then flush starts.
//     rst during FLUSH ctr=100 -> IDLE, no flush_done.
//  6. CACHE_STATS_EN: 3 hits + 2 misses -> hit_cnt=3, miss_cnt=2; a flush leaves both unchanged.

Source files
------------

// File: rtl/cache_lookup_ctrl.sv
// -----------------------------------------------------------------------------
// cache_lookup_ctrl
//
// Lookup/refill controller placed in front of a 256x1-bit valid-bit table.
// It keeps the per-line tag array, drives the table write/address/data pins,
// and consumes the table's registered read data. CPU lookups become one-cycle
// hit/miss responses. A miss runs a ready/valid refill request to memory, and
// then a single-cycle fill. A flush walks all 256 lines and clears every valid
// bit.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req_*           CPU lookup request (valid/ready/addr)
//   resp_valid/hit  one-cycle response pulse; hit=0 means the miss was refilled
//   flush_req/done  flush request pulse and completion pulse
//   mem_req_*       refill request handshake and line-aligned address
//   mem_resp_valid  refill complete
//   tbl_we/addr/wd  valid-bit table write enable, address, write data
//   tbl_rd          table read data, registered (valid one cycle after address)
//
// Optional feature (macro CACHE_STATS_EN): adds the 32-bit hit_cnt and
// miss_cnt outputs. These counters wrap, are cleared only by rst, and a flush
// does not change them.
// -----------------------------------------------------------------------------
module cache_lookup_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 2,
  parameter int INDEX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic              resp_hit,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  output logic              tbl_we,
  output logic [7:0]        tbl_addr,
  output logic              tbl_wd,
  input  logic              tbl_rd
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_FILL,
    S_FLUSH
  } state_e;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d;          // tag of the accepted request
  logic [INDEX_W-1:0] idx_q, idx_d;          // line index of the accepted request
  logic [7:0]         flush_ctr_q, flush_ctr_d;
  logic               flush_pending_q, flush_pending_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_hit_q, resp_hit_d;
  logic               flush_done_q, flush_done_d;
  logic               tag_we;
  logic               lookup_hit;

  logic [TAG_W-1:0]   tag_mem_q [2**INDEX_W];

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic               unused_offset;

  assign req_tag       = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx       = req_addr[OFFSET_W +: INDEX_W];
  assign unused_offset = ^req_addr[OFFSET_W-1:0];

  // tbl_rd holds the valid bit of idx_q only during LOOKUP.
  assign lookup_hit = tbl_rd && (tag_mem_q[idx_q] == tag_q);

  always_comb begin
    // NOTE: every signal gets a default first so that no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d         = state_q;
    tag_d           = tag_q;
    idx_d           = idx_q;
    flush_ctr_d     = flush_ctr_q;
    flush_pending_d = flush_pending_q | flush_req;
    resp_valid_d    = 1'b0;
    resp_hit_d      = 1'b0;
    flush_done_d    = 1'b0;
    req_ready       = 1'b0;
    mem_req_valid   = 1'b0;
    tbl_we          = 1'b0;
    tbl_wd          = 1'b0;
    tbl_addr        = idx_q;
    tag_we          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Present the incoming index so that the registered RD is ready in LOOKUP.
        tbl_addr  = req_idx;
        req_ready = !flush_pending_q;
        if (flush_pending_q) begin
          state_d         = S_FLUSH;
          flush_pending_d = 1'b0;
          flush_ctr_d     = 8'd0;
        end else if (req_valid) begin
          tag_d   = req_tag;
          idx_d   = req_idx;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
        end else begin
          state_d = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = S_MISS_WAIT;
      end
      S_MISS_WAIT: begin
        if (mem_resp_valid) state_d = S_FILL;
      end
      S_FILL: begin
        tbl_we       = 1'b1;
        tbl_wd       = 1'b1;
        tag_we       = 1'b1;
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      S_FLUSH: begin
        tbl_we          = 1'b1;
        tbl_addr        = flush_ctr_q;
        flush_pending_d = 1'b0;  // the running flush absorbs a new request
        flush_ctr_d     = flush_ctr_q + 8'd1;
        if (flush_ctr_q == 8'hFF) begin
          state_d      = S_IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      tag_q           <= '0;
      idx_q           <= '0;
      flush_ctr_q     <= 8'd0;
      flush_pending_q <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      flush_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      tag_q           <= tag_d;
      idx_q           <= idx_d;
      flush_ctr_q     <= flush_ctr_d;
      flush_pending_q <= flush_pending_d;
      resp_valid_q    <= resp_valid_d;
      resp_hit_q      <= resp_hit_d;
      flush_done_q    <= flush_done_d;
    end
  end

  // NOTE: the tag array has no reset. A tag is only trusted when its valid bit
  // is set, and the table clears those bits on the same rst. Leaving the array
  // without reset keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (tag_we) tag_mem_q[idx_q] <= tag_q;
  end

  assign resp_valid   = resp_valid_q;
  assign resp_hit     = resp_hit_q;
  assign flush_done   = flush_done_q;
  assign mem_req_addr = {tag_q, idx_q, {OFFSET_W{1'b0}}};

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Counters advance on the same edge that launches the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if (resp_valid_d &&  resp_hit_d) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (resp_valid_d && !resp_hit_d) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_lookup_ctrl
//
// Directed testbench for cache_lookup_ctrl. It contains a behavioural model of
// the 256x1 valid-bit table with registered RD, and it drives the memory
// handshake by hand. Inputs change 1 time unit after each rising edge, and
// outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_cache_lookup_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic        resp_valid;
  logic        resp_hit;
  logic        flush_req = 1'b0;
  logic        flush_done;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic        tbl_we;
  logic [7:0]  tbl_addr;
  logic        tbl_wd;
  logic        tbl_rd;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_lookup_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .resp_valid     (resp_valid),
    .resp_hit       (resp_hit),
    .flush_req      (flush_req),
    .flush_done     (flush_done),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .tbl_we         (tbl_we),
    .tbl_addr       (tbl_addr),
    .tbl_wd         (tbl_wd),
    .tbl_rd         (tbl_rd)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
`endif
  );

  // Valid-bit table model. It shares rst, and RD registers on non-write cycles.
  logic tbl_valid [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) tbl_valid[i] <= 1'b0;
      tbl_rd <= 1'b0;
    end else if (tbl_we) begin
      tbl_valid[tbl_addr] <= tbl_wd;
    end else begin
      tbl_rd <= tbl_valid[tbl_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one complete lookup from IDLE. On a miss it holds off mem_req_ready
  // for 'stall' cycles and checks that the request stays stable meanwhile.
  task automatic do_req(input logic [31:0] addr, input logic exp_hit,
                        input logic [7:0] exp_idx, input int stall);
    req_addr  = addr;
    req_valid = 1'b1;
    check("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0;
    check("lookup_no_resp", resp_valid, 0);
    tick();
    if (exp_hit) begin
      check("hit_resp_valid", resp_valid, 1);
      check("hit_resp_hit", resp_hit, 1);
    end else begin
      check("miss_no_early_resp", resp_valid, 0);
      for (int i = 0; i < stall; i++) begin
        check("stall_mem_req_valid", mem_req_valid, 1);
        check("stall_mem_req_addr", mem_req_addr, addr & 32'hFFFF_FFFC);
        check("stall_req_ready", req_ready, 0);
        check("stall_no_resp", resp_valid, 0);
        tick();
      end
      check("mem_req_valid", mem_req_valid, 1);
      check("mem_req_addr", mem_req_addr, addr & 32'hFFFF_FFFC);
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      check("wait_req_dropped", mem_req_valid, 0);
      check("wait_req_ready", req_ready, 0);
      mem_resp_valid = 1'b1;
      tick();
      mem_resp_valid = 1'b0;
      check("fill_we", tbl_we, 1);
      check("fill_wd", tbl_wd, 1);
      check("fill_addr", tbl_addr, exp_idx);
      tick();
      check("miss_resp_valid", resp_valid, 1);
      check("miss_resp_hit", resp_hit, 0);
    end
    tick();
    check("resp_one_cycle", resp_valid, 0);
  endtask

  // Issues a flush pulse with no other traffic and runs it to completion.
  task automatic do_flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    repeat (256) tick();
    check("flush_done_pulse", flush_done, 1);
    tick();
    check("flush_done_one_cycle", flush_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    // ---------------- reset ----------------
    #1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_flush_done", flush_done, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_tbl_we", tbl_we, 0);
    check("rst_tbl_wd", tbl_wd, 0);

    // A stray mem_resp_valid in IDLE must be ignored.
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    check("stray_mem_resp_we", tbl_we, 0);
    check("stray_mem_resp_ready", req_ready, 1);
    tick();
    check("stray_mem_resp_no_resp", resp_valid, 0);

    // ---------------- 1: miss, then hit ----------------
    do_req(32'h0000_0104, 1'b0, 8'h41, 0);
    do_req(32'h0000_0104, 1'b1, 8'h41, 0);

    // ---------------- 2: same index, other tag ----------------
    do_req(32'h0001_0104, 1'b0, 8'h41, 0);
    do_req(32'h0001_0104, 1'b1, 8'h41, 0);
    do_req(32'h0000_0104, 1'b0, 8'h41, 0);

    // ---------------- 3: memory backpressure, unaligned address ----------------
    do_req(32'h0000_220B, 1'b0, 8'h82, 5);

    // ---------------- 4: flush with request held ----------------
    do_req(32'h0000_0000, 1'b0, 8'h00, 0);
    do_req(32'h0000_03FC, 1'b0, 8'hFF, 0);
    do_req(32'h0000_03FC, 1'b1, 8'hFF, 0);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("flush_pending_blocks", req_ready, 0);
    req_addr  = 32'h0000_0000;
    req_valid = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (tbl_we !== 1'b1 || tbl_wd !== 1'b0 || tbl_addr !== 8'(i) ||
          req_ready !== 1'b0 || flush_done !== 1'b0 || resp_valid !== 1'b0)
        bad++;
      tick();
    end
    check("flush_256_writes_bad_cycles", bad, 0);
    check("flush_done", flush_done, 1);
    do_req(32'h0000_0000, 1'b0, 8'h00, 0);
    do_req(32'h0000_03FC, 1'b0, 8'hFF, 0);

    // ---------------- 5a: flush during MISS_WAIT ----------------
    req_addr  = 32'h0000_0500;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("m5_mem_req_valid", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("m5_wait_no_flush", tbl_we, 0);
    check("m5_wait_req_ready", req_ready, 0);
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    check("m5_fill_wd", tbl_wd, 1);
    tick();
    check("m5_miss_resp", resp_valid, 1);
    check("m5_miss_resp_hit", resp_hit, 0);
    check("m5_pending_blocks", req_ready, 0);
    tick();
    check("m5_flush_we", tbl_we, 1);
    check("m5_flush_first_addr", tbl_addr, 0);
    check("m5_flush_wd", tbl_wd, 0);

    // ---------------- 5b: rst at flush counter 100 ----------------
    repeat (100) tick();
    check("m5_ctr_100", tbl_addr, 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_flush_we", tbl_we, 0);
    check("rst_flush_ready", req_ready, 1);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (flush_done !== 1'b0 || tbl_we !== 1'b0) bad++;
      tick();
    end
    check("rst_flush_no_done", bad, 0);
    do_req(32'h0000_0104, 1'b0, 8'h41, 0);

    // ---------------- rst while in MISS_REQ ----------------
    req_addr  = 32'h0000_0208;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("rmiss_mem_req_valid", mem_req_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rmiss_mem_req_drop", mem_req_valid, 0);
    check("rmiss_req_ready", req_ready, 1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid !== 1'b0) bad++;
      tick();
    end
    check("rmiss_no_resp", bad, 0);

`ifdef CACHE_STATS_EN
    // ---------------- 6: statistics counters ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("stats_rst_hit", hit_cnt, 0);
    check("stats_rst_miss", miss_cnt, 0);
    do_req(32'h0000_0104, 1'b0, 8'h41, 0);
    do_req(32'h0000_0104, 1'b1, 8'h41, 0);
    do_req(32'h0000_0104, 1'b1, 8'h41, 0);
    do_req(32'h0000_0104, 1'b1, 8'h41, 0);
    do_req(32'h0000_0208, 1'b0, 8'h82, 0);
    check("stats_hit_cnt", hit_cnt, 3);
    check("stats_miss_cnt", miss_cnt, 2);
    do_flush();
    check("stats_flush_hit_cnt", hit_cnt, 3);
    check("stats_flush_miss_cnt", miss_cnt, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
